instruction_prefetch_unit: RTL

INSTRUCTION_PREFETCH_UNIT -- requirements
Module: instruction_prefetch_unit

---
 rtl/instruction_prefetch_unit_if.sv | 32 +++
 rtl/instruction_prefetch_unit.sv | 107 ++++++++++
 2 files changed

// File: rtl/instruction_prefetch_unit_if.sv
// Signal bundle between the prefetch unit, its control/memory side and the decode stage.
// The unit connects through the slave modport; the surrounding logic uses master.
interface instruction_prefetch_unit_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 20
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             Fetch_Enable;
  logic             JumpEnable;
  logic [WIDTH-1:0] JumpAddress;
  logic             Ready;
  logic [WIDTH-1:0] IMem_Data;
  logic             IMem_Request;
  logic [WIDTH-1:0] IMem_Address;
  logic [WIDTH-1:0] Instruction_Out;
  logic [WIDTH-1:0] Instruction_PC;
  logic             Instruction_Valid;
  logic [CW-1:0]    Fifo_Count;

  modport slave (
    input  Fetch_Enable, JumpEnable, JumpAddress, Ready, IMem_Data,
    output IMem_Request, IMem_Address, Instruction_Out, Instruction_PC,
           Instruction_Valid, Fifo_Count
  );

  modport master (
    output Fetch_Enable, JumpEnable, JumpAddress, Ready, IMem_Data,
    input  IMem_Request, IMem_Address, Instruction_Out, Instruction_PC,
           Instruction_Valid, Fifo_Count
  );
endinterface

// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit: issues sequential fetches into a small FIFO of (instruction, PC)
// pairs, throttled by FIFO occupancy plus the outstanding read, and flushed on a jump.
module instruction_prefetch_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 20
) (
  input logic                        Clock,
  input logic                        Reset,
  instruction_prefetch_unit_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic             r_inflight;
  logic [WIDTH-1:0] r_infl_addr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_fifo_instr [DEPTH];
  logic [WIDTH-1:0] r_fifo_pc    [DEPTH];

  logic             w_nonempty;
  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic [CW:0]      w_occupancy;
  logic             w_space;
  logic             w_req;

  assign w_nonempty = (r_count != '0);
  assign w_valid    = w_nonempty && !bus.JumpEnable;
  assign w_pop      = w_valid && bus.Ready;
  // A response arriving in a jump cycle belongs to the abandoned stream.
  assign w_push     = r_inflight && !bus.JumpEnable;
  // Pops in this cycle deliberately earn no credit: the request decision uses registered state only.
  assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_space     = (w_occupancy < LP_DEPTH);

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: begin
        w_req = bus.Fetch_Enable && !bus.JumpEnable && w_space;
        if (!bus.Fetch_Enable) w_state_nxt = S_HOLD;
      end
      S_HOLD:  if (bus.Fetch_Enable) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_inflight  <= 1'b0;
      r_infl_addr <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_req;
      if (w_req) begin
        r_infl_addr <= r_pc;
        r_pc        <= r_pc + 1'b1;
      end
      if (bus.JumpEnable) begin
        r_pc     <= bus.JumpAddress;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the count is zero.
  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= bus.IMem_Data;
      r_fifo_pc[r_wr_ptr]    <= r_infl_addr;
    end
  end

  assign bus.IMem_Request      = w_req;
  assign bus.IMem_Address      = r_pc;
  assign bus.Instruction_Valid = w_valid;
  assign bus.Instruction_Out   = w_nonempty ? r_fifo_instr[r_rd_ptr] : '0;
  assign bus.Instruction_PC    = w_nonempty ? r_fifo_pc[r_rd_ptr] : '0;
  assign bus.Fifo_Count        = r_count;
endmodule
